bus_ctrl_sequencer: RTL and testbench



---
 rtl/bus_ctrl_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_bus_ctrl_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_ctrl_sequencer.sv
// Registers one micro-op per valid/ready handshake and drives the encoded bus-control word.
// Optional feature: define BUSCTRL_CONFLICT_CHECK_EN to squash source/destination conflicts.
module bus_ctrl_sequencer #(
    parameter int REPEAT_W = 4
) (
    input  logic                Clock_In,
    input  logic                Reset_In,
    input  logic                Req_Valid,
    output logic                Req_Ready,
    input  logic [3:0]          Req_BusAssert,
    input  logic [3:0]          Req_BusLoad,
    input  logic [2:0]          Req_XferAssert,
    input  logic [3:0]          Req_XferLoadDec,
    input  logic [1:0]          Req_IncPCRA,
    input  logic [1:0]          Req_IncSPSIDI,
    input  logic [1:0]          Req_LHS,
    input  logic [1:0]          Req_RHS,
    input  logic [2:0]          Req_AddrSel,
    input  logic [REPEAT_W-1:0] Req_Repeat,
    input  logic                Mem_Wait,
    output logic [3:0]          Bus_Assert,
    output logic [3:0]          Bus_Load,
    output logic [2:0]          Xfer_Assert,
    output logic [3:0]          XferLoadDec,
    output logic [1:0]          Inc_PCRA,
    output logic [1:0]          Inc_SPSIDI,
    output logic [1:0]          LHS,
    output logic [1:0]          RHS,
    output logic [2:0]          AddrSel,
    output logic                Busy,
    output logic                Conflict
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [3:0]          MEM_BRIDGE = 4'd15;
    localparam logic [1:0]          PCRA_NONE  = 2'd3;
    localparam logic [2:0]          ADDR_NONE  = 3'd7;
    localparam logic [REPEAT_W-1:0] CNT_ONE    = 1;

    state_t              state_q, state_d;
    logic [REPEAT_W-1:0] cnt_q, cnt_d;
    logic [3:0]          bus_assert_q, bus_assert_d;
    logic [3:0]          bus_load_q, bus_load_d;
    logic [2:0]          xfer_assert_q, xfer_assert_d;
    logic [3:0]          xfer_ld_q, xfer_ld_d;
    logic [1:0]          inc_pcra_q, inc_pcra_d;
    logic [1:0]          inc_spsidi_q, inc_spsidi_d;
    logic [1:0]          lhs_q, lhs_d;
    logic [1:0]          rhs_q, rhs_d;
    logic [2:0]          addr_sel_q, addr_sel_d;
    logic                conflict_q, conflict_d;

    logic mem_op;
    logic last;
    logic accept;
    logic conflict_w;

`ifdef BUSCTRL_CONFLICT_CHECK_EN
    assign conflict_w = ((Req_BusAssert == Req_BusLoad) && (Req_BusAssert != 4'd0) &&
                         (Req_BusAssert != 4'd7)) ||
                        ((Req_XferAssert == 3'd6) && (Req_XferLoadDec == 4'd6));
`else
    assign conflict_w = 1'b0;
`endif

    // mem_op looks at the held (non one-shot) bus fields of the op in flight
    assign mem_op    = (bus_assert_q == MEM_BRIDGE) || (bus_load_q == MEM_BRIDGE);
    assign last      = (state_q == ACTIVE) && (cnt_q == '0) && !(mem_op && Mem_Wait);
    assign Req_Ready = (state_q == IDLE) || last;
    assign accept    = Req_Valid && Req_Ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bus_assert_d  = bus_assert_q;
        bus_load_d    = bus_load_q;
        xfer_assert_d = xfer_assert_q;
        xfer_ld_d     = xfer_ld_q;
        inc_pcra_d    = inc_pcra_q;
        inc_spsidi_d  = inc_spsidi_q;
        lhs_d         = lhs_q;
        rhs_d         = rhs_q;
        addr_sel_d    = addr_sel_q;
        conflict_d    = 1'b0;

        if (accept) begin
            state_d = ACTIVE;
            if (conflict_w) begin
                // Squashed op: one idle cycle with the Conflict flag raised
                cnt_d         = '0;
                bus_assert_d  = 4'd0;
                bus_load_d    = 4'd0;
                xfer_assert_d = 3'd0;
                xfer_ld_d     = 4'd0;
                inc_pcra_d    = PCRA_NONE;
                inc_spsidi_d  = 2'd0;
                lhs_d         = 2'd0;
                rhs_d         = 2'd0;
                addr_sel_d    = ADDR_NONE;
                conflict_d    = 1'b1;
            end else begin
                cnt_d         = Req_Repeat;
                bus_assert_d  = Req_BusAssert;
                bus_load_d    = Req_BusLoad;
                xfer_assert_d = Req_XferAssert;
                xfer_ld_d     = Req_XferLoadDec;
                inc_pcra_d    = Req_IncPCRA;
                inc_spsidi_d  = Req_IncSPSIDI;
                lhs_d         = Req_LHS;
                rhs_d         = Req_RHS;
                addr_sel_d    = Req_AddrSel;
            end
        end else if (last) begin
            state_d       = IDLE;
            bus_assert_d  = 4'd0;
            bus_load_d    = 4'd0;
            xfer_assert_d = 3'd0;
            xfer_ld_d     = 4'd0;
            inc_pcra_d    = PCRA_NONE;
            inc_spsidi_d  = 2'd0;
            lhs_d         = 2'd0;
            rhs_d         = 2'd0;
            addr_sel_d    = ADDR_NONE;
        end else if (state_q == ACTIVE) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_ONE;
            end
            // Increments and decrements must act once per op, not once per held cycle
            inc_pcra_d   = PCRA_NONE;
            inc_spsidi_d = 2'd0;
            if ((xfer_ld_q >= 4'd9) && (xfer_ld_q <= 4'd13)) begin
                xfer_ld_d = 4'd0;
            end
        end
    end

    always_ff @(posedge Clock_In or negedge Reset_In) begin
        if (!Reset_In) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bus_assert_q  <= 4'd0;
            bus_load_q    <= 4'd0;
            xfer_assert_q <= 3'd0;
            xfer_ld_q     <= 4'd0;
            inc_pcra_q    <= PCRA_NONE;
            inc_spsidi_q  <= 2'd0;
            lhs_q         <= 2'd0;
            rhs_q         <= 2'd0;
            addr_sel_q    <= ADDR_NONE;
            conflict_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bus_assert_q  <= bus_assert_d;
            bus_load_q    <= bus_load_d;
            xfer_assert_q <= xfer_assert_d;
            xfer_ld_q     <= xfer_ld_d;
            inc_pcra_q    <= inc_pcra_d;
            inc_spsidi_q  <= inc_spsidi_d;
            lhs_q         <= lhs_d;
            rhs_q         <= rhs_d;
            addr_sel_q    <= addr_sel_d;
            conflict_q    <= conflict_d;
        end
    end

    assign Bus_Assert  = bus_assert_q;
    assign Bus_Load    = bus_load_q;
    assign Xfer_Assert = xfer_assert_q;
    assign XferLoadDec = xfer_ld_q;
    assign Inc_PCRA    = inc_pcra_q;
    assign Inc_SPSIDI  = inc_spsidi_q;
    assign LHS         = lhs_q;
    assign RHS         = rhs_q;
    assign AddrSel     = addr_sel_q;
    assign Busy        = (state_q == ACTIVE);
    assign Conflict    = conflict_q;

endmodule

// File: tb/tb_bus_ctrl_sequencer.sv
// Bench for bus_ctrl_sequencer: directed scenarios plus randomized traffic against an op-level model.
// Expectations follow BUSCTRL_CONFLICT_CHECK_EN when it is defined for the build.
module tb_bus_ctrl_sequencer;

    typedef struct packed {
        logic [3:0] ba;
        logic [3:0] bl;
        logic [2:0] xa;
        logic [3:0] xld;
        logic [1:0] pc;
        logic [1:0] sp;
        logic [1:0] lhs;
        logic [1:0] rhs;
        logic [2:0] as;
    } word_t;

    logic       Clock_In = 1'b0;
    logic       Reset_In;
    logic       Req_Valid;
    logic       Req_Ready;
    logic [3:0] Req_BusAssert, Req_BusLoad, Req_XferLoadDec;
    logic [2:0] Req_XferAssert, Req_AddrSel;
    logic [1:0] Req_IncPCRA, Req_IncSPSIDI, Req_LHS, Req_RHS;
    logic [3:0] Req_Repeat;
    logic       Mem_Wait;
    logic [3:0] Bus_Assert, Bus_Load, XferLoadDec;
    logic [2:0] Xfer_Assert, AddrSel;
    logic [1:0] Inc_PCRA, Inc_SPSIDI, LHS, RHS;
    logic       Busy, Conflict;

    // obs layout: word fields [28:3], Busy [2], Conflict [1], Req_Ready [0]
    logic [28:0] obs;
    assign obs = {Bus_Assert, Bus_Load, Xfer_Assert, XferLoadDec, Inc_PCRA, Inc_SPSIDI,
                  LHS, RHS, AddrSel, Busy, Conflict, Req_Ready};

    int checks = 0;
    int fails  = 0;

    // Op-level model: the op in flight, how many hold cycles remain, whether it is in its first cycle
    word_t m_word;
    logic  m_busy, m_first, m_conf;
    int    m_rem;

    always #5 Clock_In = ~Clock_In;

    bus_ctrl_sequencer #(.REPEAT_W(4)) dut (
        .Clock_In(Clock_In), .Reset_In(Reset_In),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
        .Req_BusAssert(Req_BusAssert), .Req_BusLoad(Req_BusLoad),
        .Req_XferAssert(Req_XferAssert), .Req_XferLoadDec(Req_XferLoadDec),
        .Req_IncPCRA(Req_IncPCRA), .Req_IncSPSIDI(Req_IncSPSIDI),
        .Req_LHS(Req_LHS), .Req_RHS(Req_RHS), .Req_AddrSel(Req_AddrSel),
        .Req_Repeat(Req_Repeat), .Mem_Wait(Mem_Wait),
        .Bus_Assert(Bus_Assert), .Bus_Load(Bus_Load),
        .Xfer_Assert(Xfer_Assert), .XferLoadDec(XferLoadDec),
        .Inc_PCRA(Inc_PCRA), .Inc_SPSIDI(Inc_SPSIDI), .LHS(LHS), .RHS(RHS),
        .AddrSel(AddrSel), .Busy(Busy), .Conflict(Conflict)
    );

    function automatic word_t idle_word();
        word_t w;
        w = '0;
        w.pc = 2'd3;
        w.as = 3'd7;
        return w;
    endfunction

    function automatic word_t req_word();
        word_t w;
        w.ba = Req_BusAssert;  w.bl = Req_BusLoad;
        w.xa = Req_XferAssert; w.xld = Req_XferLoadDec;
        w.pc = Req_IncPCRA;    w.sp = Req_IncSPSIDI;
        w.lhs = Req_LHS;       w.rhs = Req_RHS;
        w.as = Req_AddrSel;
        return w;
    endfunction

    function automatic logic req_conflict();
`ifdef BUSCTRL_CONFLICT_CHECK_EN
        return (Req_BusAssert == Req_BusLoad && Req_BusAssert != 4'd0 && Req_BusAssert != 4'd7) ||
               (Req_XferAssert == 3'd6 && Req_XferLoadDec == 4'd6);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic m_ready();
        logic mem;
        mem = (m_word.ba == 4'd15) || (m_word.bl == 4'd15);
        return !m_busy || (m_rem == 0 && !(mem && Mem_Wait));
    endfunction

    function automatic logic [28:0] model_out();
        word_t w;
        w = idle_word();
        if (m_busy) begin
            w = m_word;
            if (!m_first) begin
                w.pc = 2'd3;
                w.sp = 2'd0;
                if (w.xld >= 4'd9 && w.xld <= 4'd13) w.xld = 4'd0;
            end
        end
        return {w, m_busy, m_busy & m_conf, m_ready()};
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_first = 1'b0; m_conf = 1'b0; m_rem = 0; m_word = idle_word();
    endtask

    task automatic model_step();
        logic c;
        if (Req_Valid && m_ready()) begin
            c       = req_conflict();
            m_busy  = 1'b1;
            m_first = 1'b1;
            m_conf  = c;
            m_word  = c ? idle_word() : req_word();
            m_rem   = c ? 0 : int'(Req_Repeat);
        end else if (m_busy) begin
            if (m_ready()) begin
                m_busy = 1'b0;
            end else begin
                if (m_rem > 0) m_rem--;
                m_first = 1'b0;
                m_conf  = 1'b0;
            end
        end
    endtask

    // Sample at the falling edge, advance the model across the rising edge, return #1 after it
    task automatic sample(output logic [28:0] o, output logic [28:0] e);
        @(negedge Clock_In);
        o = obs;
        e = model_out();
        model_step();
        @(posedge Clock_In);
        #1;
    endtask

    task automatic set_req(input logic [3:0] ba, input logic [3:0] bl, input logic [2:0] xa,
                           input logic [3:0] xld, input logic [1:0] pc, input logic [1:0] sp,
                           input logic [2:0] as, input logic [3:0] rep);
        Req_Valid = 1'b1;
        Req_BusAssert = ba; Req_BusLoad = bl; Req_XferAssert = xa; Req_XferLoadDec = xld;
        Req_IncPCRA = pc; Req_IncSPSIDI = sp; Req_LHS = 2'd1; Req_RHS = 2'd2;
        Req_AddrSel = as; Req_Repeat = rep;
    endtask

    task automatic clear_req();
        Req_Valid       = 1'b0;
        Req_BusAssert   = 4'($urandom);
        Req_BusLoad     = 4'($urandom);
        Req_XferAssert  = 3'($urandom);
        Req_XferLoadDec = 4'($urandom);
        Req_IncPCRA     = 2'($urandom);
        Req_IncSPSIDI   = 2'($urandom);
        Req_LHS         = 2'($urandom);
        Req_RHS         = 2'($urandom);
        Req_AddrSel     = 3'($urandom);
        Req_Repeat      = 4'($urandom);
    endtask

    task automatic test_reset();
        logic [28:0] o, e;
        Reset_In = 1'b0;
        Mem_Wait = 1'b1;
        clear_req();
        Req_Valid = 1'b1;
        repeat (3) @(posedge Clock_In);
        @(negedge Clock_In);
        checks++;
        if (obs !== {idle_word(), 3'b001}) begin
            fails++; $display("FAIL reset_state: got %h want %h", obs, {idle_word(), 3'b001});
        end
        clear_req();
        Mem_Wait = 1'b0;
        model_reset();
        Reset_In = 1'b1;
        @(posedge Clock_In); #1;
        set_req(4'd1, 4'd2, 3'd0, 4'd0, 2'd3, 2'd0, 3'd7, 4'd0);
        sample(o, e);
        checks++;
        if (o !== e) begin fails++; $display("FAIL reset_accept: got %h want %h", o, e); end
        clear_req();
        sample(o, e);
        checks++;
        if (o[28:21] !== 8'h12 || o[2] !== 1'b1 || o !== e) begin
            fails++; $display("FAIL reset_first_word: got %h want %h", o, e);
        end
        sample(o, e);
        checks++;
        if (o !== {idle_word(), 3'b001} || o !== e) begin
            fails++; $display("FAIL reset_back_idle: got %h want %h", o, e);
        end
    endtask

    task automatic test_repeat();
        logic [28:0] o, e;
        set_req(4'd4, 4'd5, 3'd0, 4'd9, 2'd3, 2'd1, 3'd7, 4'd3);
        sample(o, e);
        clear_req();
        for (int i = 0; i < 4; i++) begin
            sample(o, e);
            checks++;
            if (o !== e || o[11:10] !== ((i == 0) ? 2'd1 : 2'd0) ||
                o[17:14] !== ((i == 0) ? 4'd9 : 4'd0) || o[0] !== (i == 3) ||
                o[28:21] !== 8'h45) begin
                fails++; $display("FAIL repeat_cycle%0d: got %h want %h", i, o, e);
            end
        end
        sample(o, e);
        checks++;
        if (o !== e || o[2] !== 1'b0) begin fails++; $display("FAIL repeat_end: got %h want %h", o, e); end
    endtask

    task automatic test_mem_stretch();
        logic [28:0] o, e;
        Mem_Wait = 1'b0;
        set_req(4'd0, 4'd15, 3'd0, 4'd0, 2'd3, 2'd0, 3'd2, 4'd0);
        sample(o, e);
        clear_req();
        for (int i = 0; i < 4; i++) begin
            Mem_Wait = (i < 3);
            sample(o, e);
            checks++;
            if (o !== e || o[0] !== (i == 3) || o[5:3] !== 3'd2 || o[2] !== 1'b1) begin
                fails++; $display("FAIL mem_stretch_cycle%0d: got %h want %h", i, o, e);
            end
        end
        Mem_Wait = 1'b0;
        sample(o, e);
        checks++;
        if (o !== e || o[2] !== 1'b0) begin fails++; $display("FAIL mem_stretch_end: got %h want %h", o, e); end
    endtask

    task automatic test_back_to_back();
        logic [28:0] o, e;
        set_req(4'd1, 4'd3, 3'd0, 4'd0, 2'd0, 2'd0, 3'd7, 4'd1);
        sample(o, e);
        set_req(4'd2, 4'd3, 3'd0, 4'd0, 2'd0, 2'd0, 3'd7, 4'd0);
        for (int i = 0; i < 3; i++) begin
            sample(o, e);
            checks++;
            if (o !== e || o[2] !== 1'b1 || o[13:12] !== ((i == 1) ? 2'd3 : 2'd0) ||
                o[28:25] !== ((i == 2) ? 4'd2 : 4'd1)) begin
                fails++; $display("FAIL back_to_back_cycle%0d: got %h want %h", i, o, e);
            end
            if (i == 1) clear_req();
        end
        sample(o, e);
        checks++;
        if (o !== e || o[2] !== 1'b0) begin fails++; $display("FAIL back_to_back_end: got %h want %h", o, e); end
    endtask

    task automatic test_async_reset();
        logic [28:0] o, e;
        set_req(4'd5, 4'd6, 3'd1, 4'd2, 2'd1, 2'd2, 3'd3, 4'd5);
        sample(o, e);
        clear_req();
        sample(o, e);
        checks++;
        if (o !== e) begin fails++; $display("FAIL async_pre: got %h want %h", o, e); end
        #2;
        Reset_In = 1'b0;
        #1;
        checks++;
        if (obs !== {idle_word(), 3'b001}) begin
            fails++; $display("FAIL async_reset_idle: got %h want %h", obs, {idle_word(), 3'b001});
        end
        model_reset();
        @(negedge Clock_In);
        Reset_In = 1'b1;
        @(posedge Clock_In); #1;
        for (int i = 0; i < 3; i++) begin
            sample(o, e);
            checks++;
            if (o !== e || o[2] !== 1'b0) begin
                fails++; $display("FAIL async_no_residual%0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_conflict();
        logic [28:0] o, e;
        set_req(4'd3, 4'd3, 3'd0, 4'd0, 2'd3, 2'd0, 3'd7, 4'd2);
        sample(o, e);
        checks++;
        if (o !== e || o[0] !== 1'b1) begin fails++; $display("FAIL conflict_accept: got %h want %h", o, e); end
        clear_req();
        sample(o, e);
        checks++;
`ifdef BUSCTRL_CONFLICT_CHECK_EN
        if (o !== e || o !== {idle_word(), 3'b111}) begin
`else
        if (o !== e || o[28:21] !== 8'h33 || o[1] !== 1'b0) begin
`endif
            fails++; $display("FAIL conflict_issue: got %h want %h", o, e);
        end
        sample(o, e);
        checks++;
`ifdef BUSCTRL_CONFLICT_CHECK_EN
        if (o !== e || o !== {idle_word(), 3'b001}) begin
`else
        if (o !== e || o[28:21] !== 8'h33 || o[2] !== 1'b1) begin
`endif
            fails++; $display("FAIL conflict_after: got %h want %h", o, e);
        end
        for (int i = 0; i < 3; i++) begin
            sample(o, e);
            checks++;
            if (o !== e) begin fails++; $display("FAIL conflict_drain%0d: got %h want %h", i, o, e); end
        end
    endtask

    task automatic test_random();
        logic [28:0] o, e;
        for (int i = 0; i < 400; i++) begin
            clear_req();
            Req_Valid  = ($urandom_range(0, 9) < 6);
            Req_Repeat = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) Req_BusLoad = 4'd15;
            if ($urandom_range(0, 5) == 0) Req_BusLoad = Req_BusAssert;
            Mem_Wait = ($urandom_range(0, 9) < 4);
            sample(o, e);
            checks++;
            if (o !== e) begin fails++; $display("FAIL random_cycle%0d: got %h want %h", i, o, e); end
        end
        Mem_Wait = 1'b0;
        clear_req();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_repeat();
        test_mem_stretch();
        test_back_to_back();
        test_async_reset();
        test_conflict();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
